// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: opcodes, instruction
// field positions, flag indices and the decoded-instruction record.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_IN  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JN  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int SH_MSB  = 3;
    localparam int SH_LSB  = 0;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [3:0] sh;
        logic [8:0] imm9;
    } dec_t;

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/cpu_core_fetch_unit.sv
// Instruction fetch: program counter plus the instruction memory it addresses.
// The PC reloads from the reset vector held in word 0 whenever reset asserts.
module instr_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [15:0]       rdata_o,
    output logic [ADDR_W-1:0] vec_o
);
    reg [15:0] mem [0:2**ADDR_W-1];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
    assign vec_o   = mem[0][ADDR_W-1:0];
endmodule

module fetch_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              halt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [15:0]       instr_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rst_vec;

    // Contents are preloaded externally; the write port is kept for RAM use but idle here.
    instr_mem #(.ADDR_W(ADDR_W)) instr_memory (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i ('0),
        .wdata_i ('0),
        .raddr_i (pc_q),
        .rdata_o (instr_o),
        .vec_o   (rst_vec)
    );

    always_comb pc_d = halt_i ? pc_q : next_pc_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= rst_vec;
        else     pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/cpu_core.sv
// 16-bit single-cycle register CPU: decode, 8x16 register file, ALU and ZNC flags.
// One instruction per clock from fetch_unit; I/O only through in_port/out_port.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_port,
    output logic [15:0] out_port
);
    logic [15:0]       instr;
    logic [ADDR_W-1:0] pc, next_pc;
    dec_t              dec;

    logic [15:0] rf_q [8];
    logic [2:0]  flags_q, flags_d;
    logic [15:0] out_q, out_d;
    logic        halted_q, halted_d;

    logic        rf_we, upd_zn;
    logic [15:0] a, b, res;
    logic [16:0] sum, shl_w, shr_w;

    fetch_unit #(.ADDR_W(ADDR_W)) fetch_unit (
        .clk       (clk),
        .rst       (rst),
        .next_pc_i (next_pc),
        .halt_i    (halted_q),
        .pc_o      (pc),
        .instr_o   (instr)
    );

    always_comb begin
        dec.op   = instr[OP_MSB:OP_LSB];
        dec.rd   = instr[RD_MSB:RD_LSB];
        dec.rs   = instr[RS_MSB:RS_LSB];
        dec.rt   = instr[RT_MSB:RT_LSB];
        dec.sh   = instr[SH_MSB:SH_LSB];
        dec.imm9 = instr[IMM_MSB:IMM_LSB];
    end

    assign a = rf_q[dec.rs];
    assign b = rf_q[dec.rt];
    // Bit 16 of shl_w / bit 0 of shr_w catch the last bit pushed out.
    assign shl_w = {1'b0, a} << dec.sh;
    assign shr_w = {a, 1'b0} >> dec.sh;

    always_comb begin
        rf_we    = 1'b0;
        upd_zn   = 1'b0;
        res      = '0;
        sum      = '0;
        flags_d  = flags_q;
        out_d    = out_q;
        halted_d = halted_q;
        next_pc  = pc + ADDR_W'(1);
        if (!halted_q) begin
            unique case (dec.op)
                OP_NOP: ;
                OP_LDI: begin rf_we = 1'b1; res = sext9(dec.imm9); end
                OP_ADD: begin
                    sum = {1'b0, a} + {1'b0, b};
                    res = sum[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
                    flags_d[FLAG_C] = sum[16];
                end
                OP_SUB: begin
                    sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
                    res = sum[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
                    flags_d[FLAG_C] = sum[16];
                end
                OP_AND: begin res = a & b; rf_we = 1'b1; upd_zn = 1'b1; end
                OP_OR:  begin res = a | b; rf_we = 1'b1; upd_zn = 1'b1; end
                OP_NOT: begin res = ~a;    rf_we = 1'b1; upd_zn = 1'b1; end
                OP_SHL: begin
                    res = shl_w[15:0]; rf_we = 1'b1; upd_zn = 1'b1;
                    if (dec.sh != 4'd0) flags_d[FLAG_C] = shl_w[16];
                end
                OP_SHR: begin
                    res = shr_w[16:1]; rf_we = 1'b1; upd_zn = 1'b1;
                    if (dec.sh != 4'd0) flags_d[FLAG_C] = shr_w[0];
                end
                OP_IN:  begin res = in_port; rf_we = 1'b1; end
                OP_OUT: out_d = a;
                OP_JMP: next_pc = a[ADDR_W-1:0];
                OP_JZ:  if (flags_q[FLAG_Z]) next_pc = a[ADDR_W-1:0];
                OP_JN:  if (flags_q[FLAG_N]) next_pc = a[ADDR_W-1:0];
                OP_JC:  if (flags_q[FLAG_C]) next_pc = a[ADDR_W-1:0];
                OP_HLT: begin halted_d = 1'b1; next_pc = pc; end
                default: ;
            endcase
            if (upd_zn) begin
                flags_d[FLAG_Z] = (res == 16'h0000);
                flags_d[FLAG_N] = res[15];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            flags_q  <= '0;
            out_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (rf_we) rf_q[dec.rd] <= res;
            flags_q  <= flags_d;
            out_q    <= out_d;
            halted_q <= halted_d;
        end
    end

    assign out_port = out_q;
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed program table, halt/reset sequence, and a
// random program checked against an instruction-level reference model.
module tb_cpu_core;
    logic        clk;
    logic        rst;
    logic [15:0] in_port;
    logic [15:0] out_port;

    int checks = 0;
    int errors = 0;

    cpu_core #(.ADDR_W(10)) cpu (
        .clk      (clk),
        .rst      (rst),
        .in_port  (in_port),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] instr;
        logic [15:0] in_val;
        logic [2:0]  reg_idx;
        logic [15:0] exp_reg;
        logic [15:0] exp_out;
        logic [2:0]  exp_znc;
        logic [9:0]  exp_pc;
    } vec_t;

    vec_t vecs [23];

    logic [15:0] mm [1024];
    logic [15:0] m_r [8];
    logic [9:0]  m_pc;
    logic [15:0] m_out;
    logic        m_z, m_n, m_c;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input int addr, input logic [15:0] val);
        cpu.fetch_unit.instr_memory.mem[addr] = val;
        mm[addr] = val;
    endtask

    task automatic model_reset();
        m_pc = mm[0][9:0];
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
        m_out = 16'h0;
        m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
    endtask

    // Instruction-set level model: arithmetic on integers, shifts one bit at a time.
    task automatic model_step(input logic [15:0] inp);
        logic [15:0] ins, ra, rb, r;
        int unsigned s;
        int op, rd, rs, rt, sh;
        logic wr, zn;
        ins = mm[m_pc];
        op = int'(ins[15:12]); rd = int'(ins[11:9]); rs = int'(ins[8:6]);
        rt = int'(ins[5:3]);   sh = int'(ins[3:0]);
        ra = m_r[rs]; rb = m_r[rt];
        r = 16'h0; wr = 1'b0; zn = 1'b0;
        m_pc = m_pc + 10'd1;
        case (op)
            1: begin r = {{7{ins[8]}}, ins[8:0]}; wr = 1'b1; end
            2: begin s = int'(ra) + int'(rb); r = s[15:0]; m_c = (s >= 65536); wr = 1'b1; zn = 1'b1; end
            3: begin s = int'(ra) + int'(16'hFFFF ^ rb) + 1; r = s[15:0]; m_c = (s >= 65536); wr = 1'b1; zn = 1'b1; end
            4: begin r = ra & rb; wr = 1'b1; zn = 1'b1; end
            5: begin r = ra | rb; wr = 1'b1; zn = 1'b1; end
            6: begin r = ~ra; wr = 1'b1; zn = 1'b1; end
            7: begin r = ra; for (int k = 0; k < sh; k++) begin m_c = r[15]; r = r << 1; end wr = 1'b1; zn = 1'b1; end
            8: begin r = ra; for (int k = 0; k < sh; k++) begin m_c = r[0];  r = r >> 1; end wr = 1'b1; zn = 1'b1; end
            9: begin r = inp; wr = 1'b1; end
            10: m_out = ra;
            11: m_pc = ra[9:0];
            12: if (m_z) m_pc = ra[9:0];
            13: if (m_n) m_pc = ra[9:0];
            14: if (m_c) m_pc = ra[9:0];
            default: ;
        endcase
        if (zn) begin m_z = (r == 16'h0); m_n = r[15]; end
        if (wr) m_r[rd] = r;
    endtask

    initial begin
        logic [15:0] w;
        logic [15:0] out_frozen;
        rst = 1'b0;
        in_port = 16'h0;

        vecs[0]  = '{10'h010, 16'h1205, 16'h0000, 3'd1, 16'h0005, 16'h0000, 3'b000, 10'h011};
        vecs[1]  = '{10'h011, 16'h15FD, 16'h0000, 3'd2, 16'hFFFD, 16'h0000, 3'b000, 10'h012};
        vecs[2]  = '{10'h012, 16'h2650, 16'h0000, 3'd3, 16'h0002, 16'h0000, 3'b001, 10'h013};
        vecs[3]  = '{10'h013, 16'hA0C0, 16'h0000, 3'd3, 16'h0002, 16'h0002, 3'b001, 10'h014};
        vecs[4]  = '{10'h014, 16'h1200, 16'h0000, 3'd1, 16'h0000, 16'h0002, 3'b001, 10'h015};
        vecs[5]  = '{10'h015, 16'h3848, 16'h0000, 3'd4, 16'h0000, 16'h0002, 3'b101, 10'h016};
        vecs[6]  = '{10'h016, 16'h1A20, 16'h0000, 3'd5, 16'h0020, 16'h0002, 3'b101, 10'h017};
        vecs[7]  = '{10'h017, 16'hC140, 16'h0000, 3'd5, 16'h0020, 16'h0002, 3'b101, 10'h020};
        vecs[8]  = '{10'h020, 16'hD140, 16'h0000, 3'd4, 16'h0000, 16'h0002, 3'b101, 10'h021};
        vecs[9]  = '{10'h021, 16'h9C00, 16'hA5A5, 3'd6, 16'hA5A5, 16'h0002, 3'b101, 10'h022};
        vecs[10] = '{10'h022, 16'h6F80, 16'h0000, 3'd7, 16'h5A5A, 16'h0002, 3'b001, 10'h023};
        vecs[11] = '{10'h023, 16'hA1C0, 16'h0000, 3'd7, 16'h5A5A, 16'h5A5A, 3'b001, 10'h024};
        vecs[12] = '{10'h024, 16'h1201, 16'h0000, 3'd1, 16'h0001, 16'h5A5A, 3'b001, 10'h025};
        vecs[13] = '{10'h025, 16'h724F, 16'h0000, 3'd1, 16'h8000, 16'h5A5A, 3'b010, 10'h026};
        vecs[14] = '{10'h026, 16'h8241, 16'h0000, 3'd1, 16'h4000, 16'h5A5A, 3'b000, 10'h027};
        vecs[15] = '{10'h027, 16'h7242, 16'h0000, 3'd1, 16'h0000, 16'h5A5A, 3'b101, 10'h028};
        vecs[16] = '{10'h028, 16'h7240, 16'h0000, 3'd1, 16'h0000, 16'h5A5A, 3'b101, 10'h029};
        vecs[17] = '{10'h029, 16'h1007, 16'h0000, 3'd0, 16'h0007, 16'h5A5A, 3'b101, 10'h02A};
        vecs[18] = '{10'h02A, 16'h15FF, 16'h0000, 3'd2, 16'hFFFF, 16'h5A5A, 3'b101, 10'h02B};
        vecs[19] = '{10'h02B, 16'hB080, 16'h0000, 3'd2, 16'hFFFF, 16'h5A5A, 3'b101, 10'h3FF};
        vecs[20] = '{10'h3FF, 16'h0000, 16'h0000, 3'd0, 16'h0007, 16'h5A5A, 3'b101, 10'h000};
        vecs[21] = '{10'h000, 16'h0010, 16'h0000, 3'd0, 16'h0007, 16'h5A5A, 3'b101, 10'h001};
        vecs[22] = '{10'h001, 16'hF000, 16'h0000, 3'd0, 16'h0007, 16'h5A5A, 3'b101, 10'h001};

        for (int i = 0; i < 1024; i++) load(i, 16'h0000);
        load(0, 16'h0010);
        for (int i = 0; i < 23; i++) load(int'(vecs[i].addr), vecs[i].instr);

        #2 rst = 1'b1;
        #1;
        chk("reset_pc", 32'(cpu.fetch_unit.pc_q), 32'h010);
        chk("reset_out", 32'(out_port), 32'h0);
        chk("reset_flags", 32'(cpu.flags_q), 32'h0);
        chk("reset_halted", 32'(cpu.halted_q), 32'h0);
        for (int i = 0; i < 8; i++) chk($sformatf("reset_r%0d", i), 32'(cpu.rf_q[i]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("held_in_reset_pc", 32'(cpu.fetch_unit.pc_q), 32'h010);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            chk($sformatf("v%0d_fetch_pc", i), 32'(cpu.fetch_unit.pc_q), 32'(vecs[i].addr));
            in_port = vecs[i].in_val;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_reg", i), 32'(cpu.rf_q[vecs[i].reg_idx]), 32'(vecs[i].exp_reg));
            chk($sformatf("v%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
            chk($sformatf("v%0d_znc", i), 32'(cpu.flags_q), 32'(vecs[i].exp_znc));
            chk($sformatf("v%0d_next_pc", i), 32'(cpu.fetch_unit.pc_q), 32'(vecs[i].exp_pc));
        end

        chk("halted_flag", 32'(cpu.halted_q), 32'h1);
        out_frozen = 16'h5A5A;
        for (int i = 0; i < 10; i++) begin
            in_port = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("halt%0d_pc", i), 32'(cpu.fetch_unit.pc_q), 32'h001);
            chk($sformatf("halt%0d_out", i), 32'(out_port), 32'(out_frozen));
            chk($sformatf("halt%0d_r6", i), 32'(cpu.rf_q[6]), 32'hA5A5);
        end

        #2 rst = 1'b1;
        #1;
        chk("midcycle_rst_pc", 32'(cpu.fetch_unit.pc_q), 32'h010);
        chk("midcycle_rst_out", 32'(out_port), 32'h0);
        chk("midcycle_rst_halted", 32'(cpu.halted_q), 32'h0);
        chk("midcycle_rst_r7", 32'(cpu.rf_q[7]), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            load(i, w);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rand_pc", 32'(cpu.fetch_unit.pc_q), 32'(m_pc));
            in_port = 16'($urandom);
            model_step(in_port);
            @(posedge clk);
            @(negedge clk);
            chk("rand_out", 32'(out_port), 32'(m_out));
            chk("rand_znc", 32'(cpu.flags_q), 32'({m_z, m_n, m_c}));
            for (int i = 0; i < 8; i++) chk($sformatf("rand_r%0d", i), 32'(cpu.rf_q[i]), 32'(m_r[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
